// File: rtl/fp32_row_streamer.sv
// rtl/fp32_row_streamer.sv - serializes whole fp32 rows into a framed one-element-per-beat stream
module fp32_row_streamer #(
  parameter  int T     = 4,
  localparam int CNT_W = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [T*32-1:0]   row_data,
  input  logic [CNT_W:0]    row_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_fp32,
  output logic              out_row_start,
  output logic              out_row_last,
  output logic              busy
);

  localparam int LEN_W = CNT_W + 1;
  localparam logic [LEN_W-1:0] LEN_T   = LEN_W'(T);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic {S_EMPTY, S_STREAM} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [T-1:0][31:0]    r_act_buf;
  logic [LEN_W-1:0]      r_act_len;
  logic [T-1:0][31:0]    r_pend_buf;
  logic [LEN_W-1:0]      r_pend_len;
  logic                  r_pend_v;
  logic [LEN_W-1:0]      r_idx;

  logic                  w_act_v;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last_beat;
  logic [LEN_W-1:0]      w_len_eff;
  logic [LEN_W-1:0]      w_idx_nxt;
  logic                  w_load_act_in;
  logic                  w_load_act_pend;
  logic                  w_load_pend;
  logic                  w_clr_pend;

  // The active slot is occupied exactly when the FSM is streaming.
  assign w_act_v     = (r_state == S_STREAM);
  assign row_ready   = !r_pend_v;
  assign busy        = w_act_v | r_pend_v;

  assign w_accept    = row_valid & row_ready;
  assign w_beat      = w_act_v & out_ready;
  assign w_last_beat = w_beat & (r_idx == (r_act_len - LEN_ONE));

  // A zero or oversize length means "the whole row".
  assign w_len_eff   = ((row_len == '0) || (row_len > LEN_T)) ? LEN_T : row_len;

  // Outputs are decoded from registers only, so a stall holds them stable.
  assign out_valid     = w_act_v;
  assign out_fp32      = w_act_v ? r_act_buf[r_idx[CNT_W-1:0]] : 32'h0;
  assign out_row_start = w_act_v & (r_idx == '0);
  assign out_row_last  = w_act_v & (r_idx == (r_act_len - LEN_ONE));

  // State register for the active-slot FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: chooses where an accepted row lands and when pending is promoted.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_load_act_in   = 1'b0;
    w_load_act_pend = 1'b0;
    w_load_pend     = 1'b0;
    w_clr_pend      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt   = S_STREAM;
          w_load_act_in = 1'b1;
          w_idx_nxt     = '0;
        end
      end
      S_STREAM: begin
        if (w_last_beat) begin
          w_idx_nxt = '0;
          if (r_pend_v) begin
            // row_ready is low here, so no new row can collide with the promotion.
            w_load_act_pend = 1'b1;
            w_clr_pend      = 1'b1;
          end else if (w_accept) begin
            w_load_act_in = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end else begin
          if (w_beat) begin
            w_idx_nxt = r_idx + LEN_ONE;
          end
          if (w_accept) begin
            w_load_pend = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Row buffers, element index and pending flag; reset discards any buffered rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_buf  <= '0;
      r_act_len  <= '0;
      r_pend_buf <= '0;
      r_pend_len <= '0;
      r_pend_v   <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_load_act_in) begin
        r_act_buf <= row_data;
        r_act_len <= w_len_eff;
      end else if (w_load_act_pend) begin
        r_act_buf <= r_pend_buf;
        r_act_len <= r_pend_len;
      end
      if (w_load_pend) begin
        r_pend_buf <= row_data;
        r_pend_len <= w_len_eff;
      end
      if (w_load_pend) begin
        r_pend_v <= 1'b1;
      end else if (w_clr_pend) begin
        r_pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp32_row_streamer.sv
// tb/tb_fp32_row_streamer.sv - directed self-checking bench for fp32_row_streamer
module tb_fp32_row_streamer;

  localparam int T = 4;

  logic          clk;
  logic          rst_n;
  logic          row_valid;
  logic          row_ready;
  logic [127:0]  row_data;
  logic [2:0]    row_len;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_fp32;
  logic          out_row_start;
  logic          out_row_last;
  logic          busy;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        l;
    logic [31:0] c;
  } beat_t;

  beat_t       mon_q[$];
  logic [31:0] cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  fp32_row_streamer #(.T(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_len       (row_len),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_fp32      (out_fp32),
    .out_row_start (out_row_start),
    .out_row_last  (out_row_last),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted beat mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) mon_q.push_back({out_fp32, out_row_start, out_row_last, cyc});
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_row(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  function automatic logic [31:0] fkey(input logic [31:0] a);
    return a[31] ? ~a : (a | 32'h8000_0000);
  endfunction

  task automatic check_row_beats(input string tag, input logic [31:0] base, input int n);
    check({tag, "_count"}, mon_q.size(), n);
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      check({tag, "_data"},  mon_q[i].d, base + i);
      check({tag, "_start"}, mon_q[i].s, (i == 0));
      check({tag, "_last"},  mon_q[i].l, (i == n - 1));
    end
  endtask

  initial begin
    logic [11:0] pat;
    logic        p_v, p_s, p_l;
    logic [31:0] p_d;
    logic [31:0] mx;
    logic [31:0] base [3];
    int          rr_low;
    logic        acc_c;

    rst_n     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    row_len   = '0;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    step();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_fp32",  out_fp32, 0);
    check("rst_start",     out_row_start, 0);
    check("rst_last",      out_row_last, 0);
    check("rst_row_ready", row_ready, 1);
    check("rst_busy",      busy, 0);

    // Single row of 1.0, 2.0, 3.0, 4.0
    row_valid = 1'b1;
    row_data  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    row_len   = 3'd4;
    out_ready = 1'b1;
    step();
    row_valid = 1'b0;
    check("t1_b0_valid", out_valid, 1);
    check("t1_b0_data",  out_fp32, 32'h3F800000);
    check("t1_b0_start", out_row_start, 1);
    check("t1_b0_last",  out_row_last, 0);
    step();
    check("t1_b1_data",  out_fp32, 32'h40000000);
    check("t1_b1_start", out_row_start, 0);
    check("t1_b1_last",  out_row_last, 0);
    step();
    check("t1_b2_data",  out_fp32, 32'h40400000);
    check("t1_b2_last",  out_row_last, 0);
    step();
    check("t1_b3_data",  out_fp32, 32'h40800000);
    check("t1_b3_start", out_row_start, 0);
    check("t1_b3_last",  out_row_last, 1);
    step();
    check("t1_done_valid", out_valid, 0);
    check("t1_done_busy",  busy, 0);

    // Three rows back to back: expect 12 consecutive beats
    base[0] = 32'h41000000;
    base[1] = 32'h42000000;
    base[2] = 32'h43000000;
    mon_q.delete();
    out_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(base[0]);
    row_len   = 3'd4;
    step();
    row_data = mk_row(base[1]);
    step();
    row_data = mk_row(base[2]);
    rr_low = 0;
    acc_c  = 1'b0;
    for (int i = 0; i < 10 && !acc_c; i++) begin
      if (row_ready) acc_c = 1'b1;
      else rr_low++;
      step();
    end
    row_valid = 1'b0;
    check("t2_third_accepted", acc_c, 1);
    check("t2_ready_low_cycles", rr_low, 3);
    repeat (12) step();
    check("t2_count", mon_q.size(), 12);
    for (int i = 0; i < 12 && i < mon_q.size(); i++) begin
      check("t2_data",  mon_q[i].d, base[i / 4] + (i % 4));
      check("t2_start", mon_q[i].s, (i % 4 == 0));
      check("t2_last",  mon_q[i].l, (i % 4 == 3));
      check("t2_no_bubble", mon_q[i].c, mon_q[0].c + i);
    end
    check("t2_done_busy", busy, 0);

    // Stalls mid-row: outputs held, no beat lost or duplicated
    mon_q.delete();
    out_ready = 1'b0;
    row_valid = 1'b1;
    row_data  = mk_row(32'h44000000);
    row_len   = 3'd4;
    step();
    row_valid = 1'b0;
    pat = 12'b110001101001;
    for (int i = 0; i < 12; i++) begin
      out_ready = pat[i];
      p_v = out_valid;
      p_d = out_fp32;
      p_s = out_row_start;
      p_l = out_row_last;
      step();
      if (!pat[i] && p_v) begin
        check("t3_hold_valid", out_valid, p_v);
        check("t3_hold_data",  out_fp32, p_d);
        check("t3_hold_start", out_row_start, p_s);
        check("t3_hold_last",  out_row_last, p_l);
      end
    end
    out_ready = 1'b1;
    check_row_beats("t3", 32'h44000000, 4);

    // Single-element row: start and last on the same beat
    row_valid = 1'b1;
    row_data  = {96'h0, 32'hC0000000};
    row_len   = 3'd1;
    step();
    row_valid = 1'b0;
    check("t4_len1_data",  out_fp32, 32'hC0000000);
    check("t4_len1_start", out_row_start, 1);
    check("t4_len1_last",  out_row_last, 1);
    step();
    check("t4_len1_done", out_valid, 0);

    // Length 0 and T+1 both clamp to T
    mon_q.delete();
    row_valid = 1'b1;
    row_data  = mk_row(32'h45000000);
    row_len   = 3'd0;
    step();
    row_valid = 1'b0;
    repeat (5) step();
    check_row_beats("t4_len0", 32'h45000000, 4);
    mon_q.delete();
    row_valid = 1'b1;
    row_data  = mk_row(32'h46000000);
    row_len   = 3'd5;
    step();
    row_valid = 1'b0;
    repeat (5) step();
    check_row_beats("t4_len5", 32'h46000000, 4);

    // Asynchronous reset mid-row with a pending row loaded
    out_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = mk_row(32'h47000000);
    row_len   = 3'd4;
    step();
    row_data = mk_row(32'h48000000);
    step();
    row_valid = 1'b0;
    step();
    check("t5_pre_data",    out_fp32, 32'h47000002);
    check("t5_pre_pending", row_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy",  busy, 0);
    check("t5_rst_ready", row_ready, 1);
    check("t5_rst_data",  out_fp32, 0);
    #3;
    rst_n = 1'b1;
    step();
    mon_q.delete();
    row_valid = 1'b1;
    row_data  = mk_row(32'h49000000);
    row_len   = 3'd4;
    step();
    row_valid = 1'b0;
    check("t5_new_data",  out_fp32, 32'h49000000);
    check("t5_new_start", out_row_start, 1);
    repeat (4) step();
    check("t5_no_resume_valid", out_valid, 0);
    check("t5_no_resume_busy",  busy, 0);
    check_row_beats("t5_new", 32'h49000000, 4);

    // Row max over the stream: {-inf, -1.0, -3.0, -0.5} -> -0.5
    mon_q.delete();
    row_valid = 1'b1;
    row_data  = {32'hBF000000, 32'hC0400000, 32'hBF800000, 32'hFF800000};
    row_len   = 3'd4;
    step();
    row_valid = 1'b0;
    repeat (5) step();
    check("t6_count", mon_q.size(), 4);
    mx = 32'hFF800000;
    for (int i = 0; i < mon_q.size(); i++) begin
      if (fkey(mon_q[i].d) > fkey(mx)) mx = mon_q[i].d;
    end
    check("t6_row_max", mx, 32'hBF000000);
    if (mon_q.size() == 4) check("t6_last_flag", mon_q[3].l, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
